receptor_sumador: RTL and testbench

- Receive-side consumer and checker for the pipelined adder's result stream.
- Captures each issued operand pair (dataA, dataB) into a scoreboard keyed by its transaction index.
- When the adder delivers the result (sum30_dd, idx_dd), retrieves the matching operands, recomputes the expected sum and classifies the result as match, mismatch or protocol error.
- Sits beside the adder in the test environment and in on-chip self-test; drives pass/fail status and counters.

---
 rtl/receptor_sumador_if.sv | 41 ++++
 rtl/receptor_sumador.sv | 171 +++++++++++++++++
 tb/tb_receptor_sumador.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/receptor_sumador_if.sv
// Operand-issue and result-delivery bus between the pipelined adder environment
// and the receive-side checker, plus the checker's status outputs.
`timescale 1ns/1ps

interface receptor_sumador_if #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 4,
  parameter int CNT_W = 8
) ();

  logic             op_valid;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [IDX_W-1:0] op_idx;

  logic             res_valid;
  logic [WIDTH-1:0] sum30_dd;
  logic [IDX_W-1:0] idx_dd;

  logic             match;
  logic             mismatch;
  logic [1:0]       err_code;
  logic             err_sticky;
  logic [IDX_W:0]   pending;
  logic [CNT_W-1:0] ok_count;
  logic [CNT_W-1:0] bad_count;

  // The environment side issues operands and results and observes status
  modport master (
    output op_valid, dataA, dataB, op_idx,
    output res_valid, sum30_dd, idx_dd,
    input  match, mismatch, err_code, err_sticky, pending, ok_count, bad_count
  );

  modport slave (
    input  op_valid, dataA, dataB, op_idx,
    input  res_valid, sum30_dd, idx_dd,
    output match, mismatch, err_code, err_sticky, pending, ok_count, bad_count
  );

endinterface

// File: rtl/receptor_sumador.sv
// Receive-side checker for the pipelined adder: scoreboards issued operand pairs
// by index and classifies each returned sum as match, mismatch or protocol error.
`timescale 1ns/1ps

module receptor_sumador #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  receptor_sumador_if.slave bus
);

  localparam int               DEPTH   = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sb_a [DEPTH];
  logic [WIDTH-1:0] sb_b [DEPTH];
  logic [DEPTH-1:0] sb_valid, sb_valid_next;

  logic             event_in;
  logic             entry_valid;
  logic             retire;
  logic             orphan;
  logic             same_idx;
  logic             collision;
  logic             is_match;
  logic             is_mismatch;
  logic             report;
  logic [WIDTH-1:0] expected;

  logic [IDX_W:0]   pending_q, pending_next;
  logic [CNT_W-1:0] ok_q, ok_next;
  logic [CNT_W-1:0] bad_q, bad_next;
  logic [CNT_W:0]   bad_sum;
  logic [1:0]       bad_inc;

  logic             match_q, match_next;
  logic             mismatch_q, mismatch_next;
  logic [1:0]       err_q, err_next;
  logic             sticky_q, sticky_next;

  // Classify this cycle's traffic against the pre-write scoreboard contents
  always_comb begin
    event_in    = bus.op_valid | bus.res_valid;
    entry_valid = sb_valid[bus.idx_dd];
    expected    = sb_a[bus.idx_dd] + sb_b[bus.idx_dd];
    retire      = bus.res_valid & entry_valid;
    orphan      = bus.res_valid & ~entry_valid;
    same_idx    = (bus.op_idx == bus.idx_dd);
    collision   = bus.op_valid & sb_valid[bus.op_idx] & ~(retire & same_idx);
    is_match    = retire & (bus.sum30_dd == expected);
    is_mismatch = retire & (bus.sum30_dd != expected);
    report      = retire | orphan | collision;
  end

  // Retire before write so a same-index retire+issue leaves the entry valid
  always_comb begin
    sb_valid_next = sb_valid;
    if (retire) begin
      sb_valid_next[bus.idx_dd] = 1'b0;
    end
    if (bus.op_valid) begin
      sb_valid_next[bus.op_idx] = 1'b1;
    end
  end

  // The registered state describes the output stage: REPORT while a pulse or
  // error is visible, CHECK after a silent evaluation, IDLE with no traffic.
  // Every state evaluates a new event immediately, so traffic never stalls.
  always_comb begin
    state_next = IDLE;
    unique case (state)
      IDLE: begin
        if (event_in) begin
          state_next = report ? REPORT : CHECK;
        end
      end
      CHECK: begin
        if (event_in) begin
          state_next = report ? REPORT : CHECK;
        end
      end
      REPORT: begin
        if (event_in) begin
          state_next = report ? REPORT : CHECK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    match_next    = 1'b0;
    mismatch_next = 1'b0;
    err_next      = 2'b00;
    if (state_next == REPORT) begin
      match_next    = is_match;
      mismatch_next = is_mismatch;
      err_next      = {collision, orphan};
    end
    sticky_next = sticky_q | mismatch_next | (err_next != 2'b00);
  end

  // Occupancy and saturating statistics
  always_comb begin
    pending_next = pending_q
                 + {{IDX_W{1'b0}}, (bus.op_valid & ~collision)}
                 - {{IDX_W{1'b0}}, retire};

    ok_next = ok_q;
    if (is_match && (ok_q != CNT_MAX)) begin
      ok_next = ok_q + CNT_ONE;
    end

    bad_inc  = {1'b0, (is_mismatch | orphan)} + {1'b0, collision};
    bad_sum  = {1'b0, bad_q} + {{(CNT_W-1){1'b0}}, bad_inc};
    bad_next = bad_sum[CNT_W] ? CNT_MAX : bad_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset_L) begin
      state      <= IDLE;
      sb_valid   <= '0;
      pending_q  <= '0;
      ok_q       <= '0;
      bad_q      <= '0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= 2'b00;
      sticky_q   <= 1'b0;
    end else begin
      state      <= state_next;
      sb_valid   <= sb_valid_next;
      pending_q  <= pending_next;
      ok_q       <= ok_next;
      bad_q      <= bad_next;
      match_q    <= match_next;
      mismatch_q <= mismatch_next;
      err_q      <= err_next;
      sticky_q   <= sticky_next;
    end
  end

  // Operand storage needs no reset; the valid bits alone define occupancy
  always_ff @(posedge clk) begin
    if (!reset_L && bus.op_valid) begin
      sb_a[bus.op_idx] <= bus.dataA;
      sb_b[bus.op_idx] <= bus.dataB;
    end
  end

  assign bus.match      = match_q;
  assign bus.mismatch   = mismatch_q;
  assign bus.err_code   = err_q;
  assign bus.err_sticky = sticky_q;
  assign bus.pending    = pending_q;
  assign bus.ok_count   = ok_q;
  assign bus.bad_count  = bad_q;

endmodule

// File: tb/tb_receptor_sumador.sv
// Bench for receptor_sumador: directed vector table, saturation/reset sequence,
// and randomized traffic checked against an index-keyed reference model.
`timescale 1ns/1ps

module tb_receptor_sumador;

  localparam int WIDTH = 4;
  localparam int IDX_W = 4;
  localparam int CNT_W = 8;
  localparam int DEPTH = 16;
  localparam int MODW  = 16;
  localparam int CMAX  = 255;

  logic clk = 1'b0;
  logic reset_L;

  receptor_sumador_if #(.WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  receptor_sumador #(.WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit opv;
    int a;
    int b;
    int oi;
    bit rv;
    int s;
    int ri;
    bit e_match;
    bit e_mismatch;
    int e_err;
    bit e_sticky;
    int e_pending;
    int e_ok;
    int e_bad;
  } vec_t;

  vec_t tbl[$];

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Reference model: operands per index, occupancy, and expected status
  int mA [DEPTH];
  int mB [DEPTH];
  bit mV [DEPTH];
  bit x_match, x_mismatch, x_sticky;
  int x_err, x_pending, x_ok, x_bad;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic void model_step(input bit rst, input bit opv, input int a, input int b,
                                     input int oi, input bit rv, input int s, input int ri);
    bit hit, orph, coll;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mV[i] = 1'b0;
      x_match = 0; x_mismatch = 0; x_sticky = 0;
      x_err = 0; x_pending = 0; x_ok = 0; x_bad = 0;
      return;
    end
    hit  = rv && mV[ri];
    orph = rv && !mV[ri];
    coll = opv && mV[oi] && !(hit && ri == oi);
    x_match    = hit && (s == (mA[ri] + mB[ri]) % MODW);
    x_mismatch = hit && !x_match;
    x_err      = (orph ? 1 : 0) + (coll ? 2 : 0);
    x_pending  = x_pending + ((opv && !coll) ? 1 : 0) - (hit ? 1 : 0);
    x_ok       = sat(x_ok + (x_match ? 1 : 0));
    x_bad      = sat(x_bad + (x_mismatch ? 1 : 0) + (orph ? 1 : 0) + (coll ? 1 : 0));
    x_sticky   = x_sticky || x_mismatch || (x_err != 0);
    if (hit) mV[ri] = 1'b0;
    if (opv) begin
      mA[oi] = a;
      mB[oi] = b;
      mV[oi] = 1'b1;
    end
  endfunction

  function automatic vec_t mk(input bit rst, input bit opv, input int a, input int b, input int oi,
                              input bit rv, input int s, input int ri,
                              input bit em, input bit emm, input int ee, input bit es,
                              input int ep, input int eo, input int eb);
    vec_t v;
    v.rst = rst; v.opv = opv; v.a = a; v.b = b; v.oi = oi;
    v.rv = rv; v.s = s; v.ri = ri;
    v.e_match = em; v.e_mismatch = emm; v.e_err = ee; v.e_sticky = es;
    v.e_pending = ep; v.e_ok = eo; v.e_bad = eb;
    return v;
  endfunction

  // Drive one cycle of inputs, let the edge happen, advance the model, then
  // return on the falling edge where outputs are sampled
  task automatic applyStimulus(input bit rst, input bit opv, input int a, input int b, input int oi,
                               input bit rv, input int s, input int ri);
    reset_L       = rst;
    bus.op_valid  = opv;
    bus.dataA     = a[WIDTH-1:0];
    bus.dataB     = b[WIDTH-1:0];
    bus.op_idx    = oi[IDX_W-1:0];
    bus.res_valid = rv;
    bus.sum30_dd  = s[WIDTH-1:0];
    bus.idx_dd    = ri[IDX_W-1:0];
    @(posedge clk);
    model_step(rst, opv, a, b, oi, rv, s, ri);
    @(negedge clk);
  endtask

  task automatic cmp_field(input string tag, input string what, input int act, input int req);
    if (act != req) begin
      n_miscompares++;
      $display("[TB] FAIL %s %s: got %0d, expected %0d", tag, what, act, req);
    end
  endtask

  task automatic checkOutput(input string tag, input bit em, input bit emm, input int ee,
                             input bit es, input int ep, input int eo, input int eb);
    n_vectors++;
    cmp_field(tag, "match",      int'(bus.match),      int'(em));
    cmp_field(tag, "mismatch",   int'(bus.mismatch),   int'(emm));
    cmp_field(tag, "err_code",   int'(bus.err_code),   ee);
    cmp_field(tag, "err_sticky", int'(bus.err_sticky), int'(es));
    cmp_field(tag, "pending",    int'(bus.pending),    ep);
    cmp_field(tag, "ok_count",   int'(bus.ok_count),   eo);
    cmp_field(tag, "bad_count",  int'(bus.bad_count),  eb);
  endtask

  task automatic check_model(input string tag);
    checkOutput(tag, x_match, x_mismatch, x_err, x_sticky, x_pending, x_ok, x_bad);
  endtask

  initial begin
    int s, ri, oi, last_oi;

    // rst opv  a  b oi  rv  s ri | match mism err sticky pend ok bad
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 5, 2, 0,  0, 0,  0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  8, 2,  1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 9, 9, 0, 0,  0, 0,  0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  2, 0,  1, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 9, 9, 0, 0,  0, 0,  0, 0, 0, 0, 1, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  3, 0,  0, 1, 0, 1, 0, 2, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 7,  0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 4, 0,  0, 0,  0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 6, 7, 4, 0,  0, 0,  0, 0, 2, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 2, 2, 4, 1, 13, 4,  1, 0, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  4, 4,  1, 0, 0, 1, 0, 2, 1));
    tbl.push_back(mk(0, 1, 1, 1, 5, 0,  0, 0,  0, 0, 0, 1, 1, 2, 1));
    tbl.push_back(mk(0, 1, 0, 0, 5, 1,  0, 9,  0, 0, 3, 1, 1, 2, 3));
    tbl.push_back(mk(0, 1, 1, 1, 6, 0,  0, 0,  0, 0, 0, 1, 2, 2, 3));
    tbl.push_back(mk(0, 1, 2, 2, 6, 1, 15, 5,  0, 1, 2, 1, 1, 2, 5));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rst, tbl[i].opv, tbl[i].a, tbl[i].b, tbl[i].oi,
                    tbl[i].rv, tbl[i].s, tbl[i].ri);
      checkOutput($sformatf("vec%0d", i), tbl[i].e_match, tbl[i].e_mismatch, tbl[i].e_err,
                  tbl[i].e_sticky, tbl[i].e_pending, tbl[i].e_ok, tbl[i].e_bad);
    end

    // Back-to-back issue/retire stream long enough to saturate ok_count
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    check_model("sat_reset");
    last_oi = 0;
    for (int i = 0; i < 300; i++) begin
      oi = i % DEPTH;
      ri = (i + DEPTH - 1) % DEPTH;
      s  = (mA[ri] + mB[ri]) % MODW;
      applyStimulus(0, 1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), oi,
                    (i > 0), s, ri);
      check_model($sformatf("stream%0d", i));
      last_oi = oi;
    end
    checkOutput("sat_end", 1, 0, 0, 0, 1, CMAX, 0);

    // Reset in the middle of traffic wins over the concurrent op/result
    applyStimulus(1, 1, 4, 4, (last_oi + 1) % DEPTH, 1, 0, last_oi);
    checkOutput("mid_reset", 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, last_oi);
    checkOutput("post_reset_orphan", 0, 0, 1, 1, 0, 0, 1);

    // Randomized traffic on a few indices to provoke collisions and orphans
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    check_model("rand_reset");
    for (int i = 0; i < 400; i++) begin
      ri = int'($urandom_range(0, 3));
      s  = ($urandom_range(0, 3) != 0) ? (mA[ri] + mB[ri]) % MODW : int'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 99) == 0), bit'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), s, ri);
      check_model($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
